reservation_station: RTL

Per-functional-unit reservation station sitting directly downstream of the decode stage; one instance per FU, four in total.
- Accepts renamed ops (ROB tag, two operand tag/value pairs, 10-bit command word) from decode.
- Snoops the common data bus (CDB) to resolve pending operands.
- Issues one ready op per cycle to its FU through a registered valid/ready output.
- Full condition is reported back to decode as a stall.

---
 rtl/rs_pkg.sv | 34 +++
 rtl/rs_select.sv | 55 +++++
 rtl/reservation_station.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared types and constants for the reservation station.
//
// ROBsize fixes the ROB tag space: tags 1..ROBsize name ROB entries and
// tag 0 (TAG_ZERO) means the operand value is already present.
// DATA_W is the operand width and CMD_W is the command word width.
// rs_entry_t holds one station slot.
package rs_pkg;

  localparam int unsigned ROBsize = 32;
  localparam int unsigned TAGW    = $clog2(ROBsize + 1);
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned CMD_W   = 10;

  localparam logic [TAGW-1:0] TAG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [TAGW-1:0]   robTag;
    logic [TAGW-1:0]   tag1;
    logic [TAGW-1:0]   tag2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [CMD_W-1:0]  cmd;
  } rs_entry_t;

  // A CDB broadcast resolves a pending tag. Tag 0 is never matched because it
  // already means "value present".
  function automatic logic tag_hit(input logic            cdb_valid,
                                   input logic [TAGW-1:0] cdb_tag,
                                   input logic [TAGW-1:0] tag);
    return cdb_valid && (tag != TAG_ZERO) && (tag == cdb_tag);
  endfunction

endpackage

// File: rtl/rs_select.sv
// Issue selection for the reservation station.
//
// Inputs:
//   ready_i      per-entry ready flags.
//   age_i        age matrix (only when RS_OLDEST_FIRST_EN is defined);
//                age_i[i][j] = 1 means entry i is older than entry j.
// Outputs:
//   grant_o      one-hot grant for the winning entry (all zero if none ready).
//   any_ready_o  at least one entry is ready.
//
// Macro RS_OLDEST_FIRST_EN: defined selects the oldest ready entry; undefined
// selects the lowest-index ready entry.
module rs_select #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0]            ready_i,
`ifdef RS_OLDEST_FIRST_EN
  input  logic [DEPTH-1:0][DEPTH-1:0] age_i,
`endif
  output logic [DEPTH-1:0]            grant_o,
  output logic                        any_ready_o
);

`ifdef RS_OLDEST_FIRST_EN
  // blocked[i]: some other ready entry is older than entry i.
  logic [DEPTH-1:0] blocked;

  always_comb begin
    blocked = '0;
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i) begin
          blocked[i] = blocked[i] | (ready_i[j] & age_i[j][i]);
        end
      end
      grant_o[i] = ready_i[i] & ~blocked[i];
    end
  end
`else
  // Scan from the top down so the lowest ready index is written last.
  always_comb begin
    grant_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
      end
    end
  end
`endif

  assign any_ready_o = |ready_i;

endmodule

// File: rtl/reservation_station.sv
// Per-functional-unit reservation station.
//
// Accepts renamed ops from decode, resolves pending operands by snooping the
// CDB (including a same-cycle bypass on allocate), and issues one ready op per
// cycle through a registered valid/ready issue register.
//
// Ports:
//   clk_i, reset_i (async, active low), flush_i (sync clear)
//   write_en_i, robTag_i, tag1_i, tag2_i, val1_i, val2_i, commands_i : decode
//   stall_o        : station full, decode must hold
//   cdbValid_i, cdbTag_i, cdbData_i : common data bus snoop
//   issueValid_o, issueReady_i, issueRobTag_o, issueVal1_o, issueVal2_o,
//   issueCmd_o     : issue register towards the FU
//   count_o        : occupied entries, issue register excluded
//
// Macro RS_OLDEST_FIRST_EN: when defined, an age matrix tracks allocation
// order and the oldest ready entry is issued; otherwise lowest index wins.
module reservation_station
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic                         write_en_i,
  input  logic [TAGW-1:0]              robTag_i,
  input  logic [TAGW-1:0]              tag1_i,
  input  logic [TAGW-1:0]              tag2_i,
  input  logic [DATA_W-1:0]            val1_i,
  input  logic [DATA_W-1:0]            val2_i,
  input  logic [CMD_W-1:0]             commands_i,
  output logic                         stall_o,
  input  logic                         cdbValid_i,
  input  logic [TAGW-1:0]              cdbTag_i,
  input  logic [DATA_W-1:0]            cdbData_i,
  output logic                         issueValid_o,
  input  logic                         issueReady_i,
  output logic [TAGW-1:0]              issueRobTag_o,
  output logic [DATA_W-1:0]            issueVal1_o,
  output logic [DATA_W-1:0]            issueVal2_o,
  output logic [CMD_W-1:0]             issueCmd_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rs_entry_t entries_q [DEPTH];
  rs_entry_t entries_d [DEPTH];
  rs_entry_t new_entry;

  logic              issue_valid_q, issue_valid_d;
  logic [TAGW-1:0]   issue_rob_q,   issue_rob_d;
  logic [DATA_W-1:0] issue_val1_q,  issue_val1_d;
  logic [DATA_W-1:0] issue_val2_q,  issue_val2_d;
  logic [CMD_W-1:0]  issue_cmd_q,   issue_cmd_d;

  logic [DEPTH-1:0]  valid_vec;
  logic [DEPTH-1:0]  ready_vec;
  logic [DEPTH-1:0]  free_onehot;
  logic [DEPTH-1:0]  grant;
  logic              any_ready;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              alloc;
  logic              load;
  logic              hit1, hit2;

  logic [TAGW-1:0]   sel_rob;
  logic [DATA_W-1:0] sel_val1;
  logic [DATA_W-1:0] sel_val2;
  logic [CMD_W-1:0]  sel_cmd;

  // Occupancy and readiness, all from registered state.
  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    count     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      ready_vec[i] = entries_q[i].valid && (entries_q[i].tag1 == TAG_ZERO) &&
                     (entries_q[i].tag2 == TAG_ZERO);
      count        = count + CNT_W'(entries_q[i].valid);
    end
  end

  assign full = (count == CNT_W'(DEPTH));

  // Lowest-index free slot; scanned top-down so the lowest write wins.
  always_comb begin
    free_onehot = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_onehot    = '0;
        free_onehot[i] = 1'b1;
      end
    end
  end

  // Flush kills a same-cycle allocate, so the age matrix is left alone too.
  assign alloc = write_en_i & ~full & ~flush_i;

`ifdef RS_OLDEST_FIRST_EN
  // age_q[i][j] = 1: entry i is older than entry j.
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

  // The new entry becomes younger than every other slot. Relations to invalid
  // slots are rewritten when those slots are allocated, so they never matter.
  always_comb begin
    age_d = age_q;
    if (alloc) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (free_onehot[i]) begin
            age_d[i][j] = 1'b0;
          end else if (free_onehot[j]) begin
            age_d[i][j] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`endif

  rs_select #(
    .DEPTH       (DEPTH)
  ) u_select (
    .ready_i     (ready_vec),
`ifdef RS_OLDEST_FIRST_EN
    .age_i       (age_q),
`endif
    .grant_o     (grant),
    .any_ready_o (any_ready)
  );

  assign load = (~issue_valid_q | issueReady_i) & any_ready;

  // Payload of the granted entry; grant is one-hot.
  always_comb begin
    sel_rob  = '0;
    sel_val1 = '0;
    sel_val2 = '0;
    sel_cmd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_rob  = entries_q[i].robTag;
        sel_val1 = entries_q[i].val1;
        sel_val2 = entries_q[i].val2;
        sel_cmd  = entries_q[i].cmd;
      end
    end
  end

  // Incoming op, with operands the CDB resolves this very cycle.
  always_comb begin
    hit1             = tag_hit(cdbValid_i, cdbTag_i, tag1_i);
    hit2             = tag_hit(cdbValid_i, cdbTag_i, tag2_i);
    new_entry.valid  = 1'b1;
    new_entry.robTag = robTag_i;
    new_entry.tag1   = hit1 ? TAG_ZERO : tag1_i;
    new_entry.tag2   = hit2 ? TAG_ZERO : tag2_i;
    new_entry.val1   = hit1 ? cdbData_i : val1_i;
    new_entry.val2   = hit2 ? cdbData_i : val2_i;
    new_entry.cmd    = commands_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        if (tag_hit(cdbValid_i, cdbTag_i, entries_q[i].tag1)) begin
          entries_d[i].tag1 = TAG_ZERO;
          entries_d[i].val1 = cdbData_i;
        end
        if (tag_hit(cdbValid_i, cdbTag_i, entries_q[i].tag2)) begin
          entries_d[i].tag2 = TAG_ZERO;
          entries_d[i].val2 = cdbData_i;
        end
      end
      if (load && grant[i]) begin
        entries_d[i].valid = 1'b0;
      end
      if (alloc && free_onehot[i]) begin
        entries_d[i] = new_entry;
      end
      if (flush_i) begin
        entries_d[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_rob_d   = issue_rob_q;
    issue_val1_d  = issue_val1_q;
    issue_val2_d  = issue_val2_q;
    issue_cmd_d   = issue_cmd_q;
    if (flush_i) begin
      issue_valid_d = 1'b0;
    end else if (load) begin
      issue_valid_d = 1'b1;
      issue_rob_d   = sel_rob;
      issue_val1_d  = sel_val1;
      issue_val2_d  = sel_val2;
      issue_cmd_d   = sel_cmd;
    end else if (issueReady_i) begin
      issue_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      issue_valid_q <= 1'b0;
      issue_rob_q   <= '0;
      issue_val1_q  <= '0;
      issue_val2_q  <= '0;
      issue_cmd_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      issue_valid_q <= issue_valid_d;
      issue_rob_q   <= issue_rob_d;
      issue_val1_q  <= issue_val1_d;
      issue_val2_q  <= issue_val2_d;
      issue_cmd_q   <= issue_cmd_d;
    end
  end

  assign stall_o       = full;
  assign count_o       = count;
  assign issueValid_o  = issue_valid_q;
  assign issueRobTag_o = issue_rob_q;
  assign issueVal1_o   = issue_val1_q;
  assign issueVal2_o   = issue_val2_q;
  assign issueCmd_o    = issue_cmd_q;

endmodule
